// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-register sequencer: FSM states, mode values
// and the count-width helper used to size count/amt fields.
package shift_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

  localparam logic MODE_NORM  = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Wide enough to hold 0..size inclusive.
  function automatic int cw_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/shift_count_ctr.sv
// Shift counter: up-counter with synchronous clear and increment enable.
// Latency: count updates on the edge after clr/inc; no backpressure.
module shift_count_ctr #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/shift_norm_ctrl.sv
// Sequencer that loads an operand into the shift register and shifts until MSB=1 or a count is reached.
// Latency: done rises 2+k edges after start for k shifts; holds in DONE until ack.
module shift_norm_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter  int SIZE = 8,
  localparam int CW   = cw_width(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [CW-1:0]   amt,
  input  logic [SIZE-1:0] op_in,
  input  logic            ack,
  input  logic [SIZE-1:0] sr_q,
  output logic            sr_load,
  output logic            sr_shift_en,
  output logic            sr_serial_in,
  output logic [SIZE-1:0] sr_data,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   count,
  output logic            zero
);

  localparam logic [CW-1:0] SIZE_CW = CW'(SIZE);

  state_t        state;
  logic          mode_q;
  logic [CW-1:0] amt_q;
  logic [CW-1:0] amt_clamped;
  logic          zero_now;
  logic          stop_now;
  logic          ctr_clr;

  assign sr_serial_in = 1'b0;
  assign amt_clamped  = (amt > SIZE_CW) ? SIZE_CW : amt;

  // Stop test looks at the register contents of this cycle, so shift_en is combinational.
  always_comb begin
    zero_now = (sr_q == '0);
    stop_now = 1'b0;
    if (mode_q == MODE_NORM) begin
      stop_now = zero_now || sr_q[SIZE-1];
    end else begin
      stop_now = (count == amt_q);
    end
    sr_shift_en = (state == S_SHIFT) && !stop_now;
    ctr_clr     = (state == S_IDLE) && start;
  end

  shift_count_ctr #(.CW(CW)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .inc   (sr_shift_en),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      mode_q  <= MODE_NORM;
      amt_q   <= '0;
      sr_data <= '0;
      zero    <= 1'b0;
      sr_load <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            amt_q   <= amt_clamped;
            sr_data <= op_in;
            zero    <= 1'b0;
            sr_load <= 1'b1;
            busy    <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          sr_load <= 1'b0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (stop_now) begin
            zero  <= (mode_q == MODE_NORM) && zero_now;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // A start coinciding with ack is dropped; it must be re-asserted in IDLE.
          if (ack) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_norm_ctrl.sv
// Directed bench for shift_norm_ctrl with a behavioural shift register on sr_* and
// hand-computed expectations for latency, pulse counts, count/zero and final register value.
module tb_shift_norm_ctrl;

  localparam int SIZE = 8;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            mode;
  logic [CW-1:0]   amt;
  logic [SIZE-1:0] op_in;
  logic            ack;
  logic [SIZE-1:0] sr_q;
  logic            sr_load;
  logic            sr_shift_en;
  logic            sr_serial_in;
  logic [SIZE-1:0] sr_data;
  logic            busy;
  logic            done;
  logic [CW-1:0]   count;
  logic            zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_norm_ctrl #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .amt          (amt),
    .op_in        (op_in),
    .ack          (ack),
    .sr_q         (sr_q),
    .sr_load      (sr_load),
    .sr_shift_en  (sr_shift_en),
    .sr_serial_in (sr_serial_in),
    .sr_data      (sr_data),
    .busy         (busy),
    .done         (done),
    .count        (count),
    .zero         (zero)
  );

  // Shift register being controlled; shares the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             sr_q <= '0;
    else if (sr_load)     sr_q <= sr_data;
    else if (sr_shift_en) sr_q <= {sr_q[SIZE-2:0], sr_serial_in};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".sr_load"},     {31'd0, sr_load},     32'd0);
    check_eq({tag, ".sr_shift_en"}, {31'd0, sr_shift_en}, 32'd0);
    check_eq({tag, ".busy"},        {31'd0, busy},        32'd0);
    check_eq({tag, ".done"},        {31'd0, done},        32'd0);
  endtask

  // Launch one operation and run to DONE. poke_at >= 0 pulses start (with a
  // different operand) and ack at that edge count while the op is in flight.
  task automatic run_op(input string tag, input logic m, input logic [CW-1:0] a,
                        input logic [SIZE-1:0] op, input int exp_k, input logic exp_zero,
                        input logic [SIZE-1:0] exp_q, input int poke_at);
    int edges  = 0;
    int pulses = 0;
    int loads  = 0;
    int both   = 0;
    @(negedge clk);
    start = 1'b1; mode = m; amt = a; op_in = op;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op_in = 8'h5A;
    while (!done && edges < 40) begin
      if (sr_load)                loads++;
      if (sr_shift_en)            pulses++;
      if (sr_load && sr_shift_en) both++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = (edges == poke_at);
      ack   = (edges == poke_at);
      if (edges == poke_at) begin
        mode = 1'b1; amt = 4'd0; op_in = 8'hFF;
      end
    end
    start = 1'b0; ack = 1'b0;
    check_eq({tag, ".done_edge"}, edges,             2 + exp_k);
    check_eq({tag, ".pulses"},    pulses,            exp_k);
    check_eq({tag, ".loads"},     loads,             1);
    check_eq({tag, ".overlap"},   both,              0);
    check_eq({tag, ".count"},     {28'd0, count},    exp_k);
    check_eq({tag, ".zero"},      {31'd0, zero},     {31'd0, exp_zero});
    check_eq({tag, ".sr_q"},      {24'd0, sr_q},     {24'd0, exp_q});
    check_eq({tag, ".sr_data"},   {24'd0, sr_data},  {24'd0, op});
    check_eq({tag, ".busy"},      {31'd0, busy},     32'd0);
    check_eq({tag, ".done_ctl"},  {30'd0, sr_load, sr_shift_en}, 32'd0);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    check_idle_outputs({tag, ".ack"});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; amt = '0; op_in = '0; ack = 1'b0;
    #12;
    check_idle_outputs("rst");
    check_eq("rst.count",     {28'd0, count},        32'd0);
    check_eq("rst.zero",      {31'd0, zero},         32'd0);
    check_eq("rst.sr_data",   {24'd0, sr_data},      32'd0);
    check_eq("rst.serial_in", {31'd0, sr_serial_in}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("norm16", 1'b0, 4'd0,  8'b0001_0110, 3, 1'b0, 8'b1011_0000, -1);
    do_ack("norm16");
    run_op("norm80", 1'b0, 4'd0,  8'h80, 0, 1'b0, 8'h80, -1);
    do_ack("norm80");
    run_op("norm00", 1'b0, 4'd0,  8'h00, 0, 1'b1, 8'h00, -1);
    do_ack("norm00");
    run_op("fix5",   1'b1, 4'd5,  8'hFF, 5, 1'b0, 8'hE0, -1);
    do_ack("fix5");
    run_op("fix15",  1'b1, 4'd15, 8'hFF, 8, 1'b0, 8'h00, -1);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("hold.done",  {31'd0, done},  32'd1);
      check_eq("hold.count", {28'd0, count}, 32'd8);
    end

    // ack with start in DONE: back to IDLE and no new load.
    start = 1'b1; ack = 1'b1; mode = 1'b0; op_in = 8'h01;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    check_idle_outputs("ackstart");
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("ackstart2");

    // start and ack while shifting are ignored.
    run_op("poke", 1'b0, 4'd0, 8'h01, 7, 1'b0, 8'h80, 4);
    do_ack("poke");

    // Reset in the middle of SHIFT.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; op_in = 8'h01;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check_eq("midrst.count",   {28'd0, count},   32'd0);
    check_eq("midrst.zero",    {31'd0, zero},    32'd0);
    check_eq("midrst.sr_data", {24'd0, sr_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("postrst", 1'b0, 4'd0, 8'b0001_0110, 3, 1'b0, 8'b1011_0000, -1);
    do_ack("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
